scan_rx: RTL and testbench
==========================

# scan_rx

Host-side receiver for the dual-scanner double-buffer transfer interface. Watches both scanners' ready-to-transfer flags, issues the active-low transfer request, and collects the resulting byte burst. Bursts are buffered in a 16-entry FIFO for the downstream host reader. Also reports per-burst length, 8-bit checksum, timeout and overflow status.

## Interface
- BURST_LEN, 100: bytes expected per burst; matches the scanner buffer size.
- TIMEOUT, 255: idle cycles in RECV with no accepted byte before the burst is aborted.
- FIFO_DEPTH, 16: FIFO entries; must be a power of two.
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  when 1, the block may start new bursts.
- ready_a  input  1  scanner 1 ready to transfer.
- ready_b  input  1  scanner 2 ready to transfer.
- transfer_n  output  1  active-low transfer request to the scanner side.
- sel  output  1  scanner being served: 0 = scanner 1, 1 = scanner 2.
- data_valid  input  1  a byte is present on data_in this cycle.
- data_src  input  1  source of data_in: 0 = scanner 1, 1 = scanner 2.
- data_in  input  8  transferred byte.
- rd_en  input  1  host pops one FIFO entry.
- rd_data  output  8  FIFO head; registered and updated on a pop.
- empty  output  1  FIFO empty.
- full  output  1  FIFO full.
- busy  output  1  state is not IDLE.
- burst_done  output  1  one-cycle pulse at burst end.
- last_count  output  8  bytes accepted in the last burst.
- last_sum  output  8  mod-256 sum of the bytes accepted in the last burst.
- err_timeout  output  1  sticky; set when a burst is aborted by timeout.
- err_overflow  output  1  sticky; set when a byte is dropped because the FIFO is full.

## Operation
- Reset (rst=0, async): state IDLE; transfer_n=1; sel=0; rd_data=0; empty=1; full=0; busy=0; burst_done=0; last_count=0; last_sum=0; err_timeout=0; err_overflow=0; FIFO pointers, burst counters and round-robin history cleared.
- State IDLE:
  - Move to REQ when enable=1 and ready_a|ready_b.
  - If only one scanner is ready, serve it.
  - If both are ready, serve the scanner not served last. After reset, scanner 1 goes first.
  - Latch sel; clear the byte count, sum and timeout counter.
- State REQ: transfer_n=0 for exactly one cycle, then RECV.
- State RECV:
  - A byte is accepted when data_valid=1 and data_src==sel.
  - Bytes with data_src!=sel are ignored. They are not counted, not summed and do not reset the timeout.
  - Each accepted byte increments the count, is added to the sum mod 256, resets the timeout counter, and is pushed to the FIFO if not full.
  - If the FIFO is full, the byte is dropped and err_overflow is set. The byte is still counted and summed.
  - The BURST_LEN-th accepted byte moves the block to DONE.
  - Each cycle with no accepted byte increments the timeout counter. When it reaches TIMEOUT: set err_timeout and move to DONE.
- State DONE: one cycle; burst_done=1; last_count and last_sum take the burst values; then IDLE.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Simultaneous push and pop while full: the pop frees the slot first, so the push succeeds and full stays 1.
  - Pop while empty is ignored; rd_data holds.
- Sticky errors clear only on reset.
- Deasserting enable does not abort a burst in progress.

## Timing
- Request latency: ready seen in IDLE at edge N → transfer_n=0 during cycle N+1 → RECV from edge N+2.
- Accept-to-FIFO latency is one cycle: empty falls the cycle after the first accepted push. rd_data is valid on the cycle after rd_en.
- burst_done pulses the cycle after the last byte or the timeout. The earliest next transfer_n=0 is 2 cycles after burst_done.
- Minimum burst turnaround, excluding data: 3 cycles (REQ, DONE, IDLE).
- Asynchronous reset mid-burst: immediately returns all state to reset values. No burst_done is produced.

## Test plan
- Reset, then ready_a=1, enable=1, 100 bytes 0x01..0x64 from src 0, host pops continuously → one transfer_n low pulse with sel=0; burst_done; last_count=100; last_sum=0xBA; all 100 bytes read in order; no errors.
- ready_a=ready_b=1 held for two bursts → first burst has sel=0, second has sel=1; transfer_n pulses 3+100 cycles apart.
- Burst of 100 bytes with no pops → FIFO holds the first 16; full=1; err_overflow=1; last_count=100; rd_data sequence is bytes 1..16.
- Burst stops after 40 bytes → burst_done exactly 255 idle cycles after byte 40; err_timeout=1; last_count=40.
- Bytes with data_src=1 interleaved during a sel=0 burst → ignored bytes are excluded from count, sum and FIFO; count reaches 100 on src-0 bytes only.
- rst pulled low after 50 bytes → outputs return to reset values immediately; no burst_done; next burst starts cleanly with sel=0.

Source files
------------

// File: rtl/scan_rx.sv
// scan_rx -- host-side receiver for the dual-scanner double-buffer transfer
// interface. Watches both scanners' ready flags, issues a one-cycle active-low
// transfer request, collects the resulting byte burst into a FIFO for the host
// and reports per-burst length, checksum and sticky timeout/overflow errors.
//
// Ports:
//   clk          single clock, all logic on posedge
//   rst          asynchronous, active-low reset
//   enable       allows new bursts to start
//   ready_a/b    scanner 1 / scanner 2 ready to transfer
//   transfer_n   active-low transfer request (one cycle)
//   sel          scanner being served (0 = scanner 1, 1 = scanner 2)
//   data_valid   byte present on data_in
//   data_src     source of data_in
//   data_in      transferred byte
//   rd_en        host pops one FIFO entry
//   rd_data      registered FIFO head, updated on a pop
//   empty/full   FIFO status
//   busy         state is not IDLE
//   burst_done   one-cycle pulse at burst end
//   last_count   bytes accepted in the last burst
//   last_sum     mod-256 sum of the bytes accepted in the last burst
//   err_timeout  sticky: a burst was aborted by timeout
//   err_overflow sticky: a byte was dropped on a full FIFO
module scan_rx #(
  parameter int BURST_LEN  = 100,
  parameter int TIMEOUT    = 255,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ready_a,
  input  logic       ready_b,
  output logic       transfer_n,
  output logic       sel,
  input  logic       data_valid,
  input  logic       data_src,
  input  logic [7:0] data_in,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       busy,
  output logic       burst_done,
  output logic [7:0] last_count,
  output logic [7:0] last_sum,
  output logic       err_timeout,
  output logic       err_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_e;

  state_e          state_q, state_d;
  logic            sel_q, sel_d;
  logic            last_sel_q, last_sel_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      sum_q, sum_d;
  logic [TW-1:0]   to_q, to_d;
  logic [7:0]      last_count_q, last_count_d;
  logic [7:0]      last_sum_q, last_sum_d;
  logic            err_to_q, err_to_d;
  logic            err_ov_q, err_ov_d;
  logic [AW:0]     wptr_q, rptr_q;
  logic [7:0]      rd_data_q;
  logic [7:0]      mem [FIFO_DEPTH];

  logic accept, pop, push, start, burst_end, to_expire;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign accept    = (state_q == RECV) && data_valid && (data_src == sel_q);
  assign pop       = rd_en && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push      = accept && (!full || pop);
  assign start     = (state_q == IDLE) && (state_d == REQ);
  assign burst_end = accept && (cnt_q == 8'(BURST_LEN - 1));
  assign to_expire = (state_q == RECV) && !accept && (to_q == TW'(TIMEOUT - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && (ready_a || ready_b)) state_d = REQ;
      REQ:     state_d = RECV;
      RECV:    if (burst_end || to_expire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    transfer_n = 1'b1;
    busy       = 1'b1;
    burst_done = 1'b0;
    case (state_q)
      IDLE:    busy       = 1'b0;
      REQ:     transfer_n = 1'b0;
      DONE:    burst_done = 1'b1;
      default: ;
    endcase
  end

  // Burst bookkeeping
  always_comb begin
    sel_d        = sel_q;
    last_sel_d   = last_sel_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    to_d         = to_q;
    last_count_d = last_count_q;
    last_sum_d   = last_sum_q;
    err_to_d     = err_to_q;
    err_ov_d     = err_ov_q;
    if (start) begin
      // Round-robin only matters when both are ready; otherwise serve whoever is.
      sel_d      = (ready_a && ready_b) ? ~last_sel_q : ready_b;
      last_sel_d = sel_d;
      cnt_d      = '0;
      sum_d      = '0;
      to_d       = '0;
    end
    if (state_q == RECV) begin
      if (accept) begin
        cnt_d = cnt_q + 8'd1;
        sum_d = sum_q + data_in;
        to_d  = '0;
        if (!push) err_ov_d = 1'b1;
      end else begin
        to_d = to_q + 1'b1;
        if (to_expire) err_to_d = 1'b1;
      end
      // Publish results on entry to DONE so they are valid alongside burst_done.
      if (burst_end || to_expire) begin
        last_count_d = cnt_d;
        last_sum_d   = sum_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q        <= 1'b0;
      last_sel_q   <= 1'b1;  // makes scanner 1 win the first contention
      cnt_q        <= '0;
      sum_q        <= '0;
      to_q         <= '0;
      last_count_q <= '0;
      last_sum_q   <= '0;
      err_to_q     <= 1'b0;
      err_ov_q     <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      rd_data_q    <= '0;
    end else begin
      sel_q        <= sel_d;
      last_sel_q   <= last_sel_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      to_q         <= to_d;
      last_count_q <= last_count_d;
      last_sum_q   <= last_sum_d;
      err_to_q     <= err_to_d;
      err_ov_q     <= err_ov_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q    <= rptr_q + 1'b1;
        rd_data_q <= mem[rptr_q[AW-1:0]];
      end
    end
  end

  // FIFO storage carries no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= data_in;
  end

  assign sel          = sel_q;
  assign rd_data      = rd_data_q;
  assign last_count   = last_count_q;
  assign last_sum     = last_sum_q;
  assign err_timeout  = err_to_q;
  assign err_overflow = err_ov_q;

endmodule

// File: tb/tb_scan_rx.sv
module tb_scan_rx;

  logic       clk, rst, enable, ready_a, ready_b, transfer_n, sel;
  logic       data_valid, data_src, rd_en, empty, full, busy, burst_done;
  logic       err_timeout, err_overflow;
  logic [7:0] data_in, rd_data, last_count, last_sum;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tn_cnt   = 0;
  int tn_last  = 0;
  int tn_prev  = 0;
  int bd_cnt   = 0;
  int bd0      = 0;
  int k        = 0;

  scan_rx #(.BURST_LEN(100), .TIMEOUT(255), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ready_a(ready_a), .ready_b(ready_b),
    .transfer_n(transfer_n), .sel(sel), .data_valid(data_valid), .data_src(data_src),
    .data_in(data_in), .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .busy(busy), .burst_done(burst_done), .last_count(last_count), .last_sum(last_sum),
    .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Event monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (rst && !transfer_n) begin
      tn_cnt++;
      tn_prev = tn_last;
      tn_last = cyc;
    end
    if (rst && burst_done) bd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    enable = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    data_valid = 1'b0; data_src = 1'b0; data_in = 8'h00; rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic send(input logic src, input int n, input bit chk);
    for (int i = 1; i <= n; i++) begin
      data_valid = 1'b1;
      data_src   = src;
      data_in    = 8'(i);
      tick();
      if (chk && i >= 2) check("rd_stream", 32'(rd_data), 32'(i - 1));
    end
    data_valid = 1'b0;
  endtask

  initial begin
    // Reset values
    rst = 1'b0;
    enable = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    data_valid = 1'b0; data_src = 1'b0; data_in = 8'h00; rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_transfer_n", 32'(transfer_n), 32'd1);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_burst_done", 32'(burst_done), 32'd0);
    check("rst_last_count", 32'(last_count), 32'd0);
    check("rst_last_sum", 32'(last_sum), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    check("rst_err_overflow", 32'(err_overflow), 32'd0);
    rst = 1'b1;

    // Basic burst from scanner 1 with continuous pops
    enable = 1'b1; ready_a = 1'b1;
    tick();
    check("t1_req_transfer_n", 32'(transfer_n), 32'd0);
    check("t1_req_sel", 32'(sel), 32'd0);
    check("t1_req_busy", 32'(busy), 32'd1);
    ready_a = 1'b0; rd_en = 1'b1;
    tick();
    check("t1_recv_transfer_n", 32'(transfer_n), 32'd1);
    send(1'b0, 100, 1'b1);
    check("t1_burst_done", 32'(burst_done), 32'd1);
    tick();
    check("t1_burst_done_low", 32'(burst_done), 32'd0);
    check("t1_rd_last", 32'(rd_data), 32'd100);
    check("t1_last_count", 32'(last_count), 32'd100);
    check("t1_last_sum", 32'(last_sum), 32'hBA);
    check("t1_empty", 32'(empty), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_err_ov", 32'(err_overflow), 32'd0);
    check("t1_err_to", 32'(err_timeout), 32'd0);
    check("t1_tn_pulses", 32'(tn_cnt), 32'd1);
    check("t1_bd_pulses", 32'(bd_cnt), 32'd1);

    // Both ready: round-robin across two back-to-back bursts
    do_reset();
    enable = 1'b1; rd_en = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    tick();
    check("t2_req1_transfer_n", 32'(transfer_n), 32'd0);
    check("t2_req1_sel", 32'(sel), 32'd0);
    tick();
    send(1'b0, 100, 1'b1);
    tick();
    check("t2_idle_busy", 32'(busy), 32'd0);
    tick();
    check("t2_req2_transfer_n", 32'(transfer_n), 32'd0);
    check("t2_req2_sel", 32'(sel), 32'd1);
    ready_a = 1'b0; ready_b = 1'b0;
    tick();
    check("t2_tn_spacing", 32'(tn_last - tn_prev), 32'd103);
    send(1'b1, 100, 1'b1);
    tick();
    check("t2_last_count", 32'(last_count), 32'd100);
    check("t2_last_sum", 32'(last_sum), 32'hBA);

    // No pops: FIFO fills, overflow flagged, first 16 bytes kept
    do_reset();
    enable = 1'b1; ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    tick();
    for (int i = 1; i <= 100; i++) begin
      data_valid = 1'b1; data_src = 1'b0; data_in = 8'(i);
      tick();
      if (i == 15) check("t3_full_at_15", 32'(full), 32'd0);
      if (i == 16) check("t3_full_at_16", 32'(full), 32'd1);
      if (i == 16) check("t3_ov_at_16", 32'(err_overflow), 32'd0);
      if (i == 17) check("t3_ov_at_17", 32'(err_overflow), 32'd1);
    end
    data_valid = 1'b0;
    tick();
    check("t3_last_count", 32'(last_count), 32'd100);
    check("t3_last_sum", 32'(last_sum), 32'hBA);
    check("t3_full", 32'(full), 32'd1);
    check("t3_err_ov", 32'(err_overflow), 32'd1);
    rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("t3_rd_seq", 32'(rd_data), 32'(i));
    end
    check("t3_empty", 32'(empty), 32'd1);
    tick();
    check("t3_rd_hold_empty", 32'(rd_data), 32'd16);
    check("t3_full_after", 32'(full), 32'd0);
    rd_en = 1'b0;

    // Timeout after 40 bytes
    do_reset();
    enable = 1'b1; rd_en = 1'b1; ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    tick();
    send(1'b0, 40, 1'b1);
    k = 0;
    while (k < 400) begin
      tick();
      k++;
      if (burst_done) break;
    end
    check("t4_timeout_cycles", 32'(k), 32'd255);
    check("t4_err_to", 32'(err_timeout), 32'd1);
    tick();
    check("t4_last_count", 32'(last_count), 32'd40);
    check("t4_last_sum", 32'(last_sum), 32'h34);
    check("t4_err_ov", 32'(err_overflow), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);

    // Foreign-source bytes interleaved are ignored
    do_reset();
    enable = 1'b1; rd_en = 1'b1; ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    tick();
    bd0 = bd_cnt;
    for (int i = 1; i <= 100; i++) begin
      data_valid = 1'b1; data_src = 1'b0; data_in = 8'(i);
      tick();
      if (i < 100) begin
        data_src = 1'b1; data_in = 8'hFF;
        tick();
        check("t5_rd_seq", 32'(rd_data), 32'(i));
      end
    end
    check("t5_burst_done", 32'(burst_done), 32'd1);
    data_valid = 1'b0;
    tick();
    check("t5_rd_last", 32'(rd_data), 32'd100);
    check("t5_last_count", 32'(last_count), 32'd100);
    check("t5_last_sum", 32'(last_sum), 32'hBA);
    check("t5_bd_pulses", 32'(bd_cnt - bd0), 32'd1);

    // Asynchronous reset mid-burst
    do_reset();
    enable = 1'b1; ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    tick();
    bd0 = bd_cnt;
    send(1'b0, 50, 1'b0);
    check("t6_pre_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_transfer_n", 32'(transfer_n), 32'd1);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_full", 32'(full), 32'd0);
    check("t6_err_ov", 32'(err_overflow), 32'd0);
    check("t6_burst_done", 32'(burst_done), 32'd0);
    check("t6_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    check("t6_no_burst_done", 32'(bd_cnt - bd0), 32'd0);
    check("t6_last_count", 32'(last_count), 32'd0);
    ready_a = 1'b1; ready_b = 1'b1;
    tick();
    check("t6_next_transfer_n", 32'(transfer_n), 32'd0);
    check("t6_next_sel", 32'(sel), 32'd0);
    ready_a = 1'b0; ready_b = 1'b0; enable = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
